// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port RAM between the CPU
// load/store path and an external master, and stalls the CPU while it waits.
module dmem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic              iclk,
   input  logic              irst_n,
   input  logic              iCpuRead,
   input  logic              iCpuWrite,
   input  logic [ADDR_W-1:0] iCpuAddr,
   input  logic [DATA_W-1:0] iCpuWData,
   output logic [DATA_W-1:0] oCpuRData,
   output logic              oCpuValid,
   output logic              oStall,
   input  logic              iExtReq,
   input  logic              iExtWe,
   input  logic [ADDR_W-1:0] iExtAddr,
   input  logic [DATA_W-1:0] iExtWData,
   output logic              oExtGnt,
   output logic [DATA_W-1:0] oExtRData,
   output logic              oExtValid,
   output logic              oMemEn,
   output logic              oMemWe,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic [DATA_W-1:0] oMemWData,
   input  logic [DATA_W-1:0] iMemRData
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE,
      RDWAIT,
      DONE
   } cpuState_t;

   cpuState_t        state;
   cpuState_t        stateNext;
   logic [CNT_W-1:0] extWait;
   logic             cpuAny;
   logic             cpuReq;
   logic             extWin;
   logic             cpuWin;
   logic             writeWin;
   logic             readWin;
   logic             extRd1;

   // Arbitration: starved external first, then CPU, then external
   always_comb begin
      cpuAny   = iCpuRead | iCpuWrite;
      cpuReq   = cpuAny & (state == IDLE);
      extWin   = irst_n & iExtReq
               & ((extWait == CNT_W'(MAX_WAIT)) | ~cpuReq);
      cpuWin   = irst_n & cpuReq & ~extWin;
      writeWin = cpuWin & iCpuWrite;
      readWin  = cpuWin & ~iCpuWrite;
   end

   // RAM port driven by the winner of this cycle
   always_comb begin
      oExtGnt   = extWin;
      oMemEn    = cpuWin | extWin;
      oMemWe    = extWin ? iExtWe    : writeWin;
      oMemAddr  = extWin ? iExtAddr  : iCpuAddr;
      oMemWData = extWin ? iExtWData : iCpuWData;
   end

   // CPU FSM next state and stall generation
   always_comb begin
      stateNext = state;
      oStall    = 1'b0;
      unique case (state)
         IDLE: begin
            if (readWin) stateNext = RDWAIT;
            oStall = irst_n & cpuAny & ~writeWin;
         end
         RDWAIT: begin
            stateNext = DONE;
            oStall    = irst_n & cpuAny;
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // CPU FSM state, load data capture and valid pulse
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state     <= IDLE;
         oCpuRData <= '0;
         oCpuValid <= 1'b0;
      end else begin
         state     <= stateNext;
         oCpuValid <= (state == RDWAIT);
         if (state == RDWAIT) oCpuRData <= iMemRData;
      end
   end

   // Starvation counter: counts consecutive denied external cycles
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         extWait <= '0;
      end else if (!iExtReq || extWin) begin
         extWait <= '0;
      end else if (extWait != CNT_W'(MAX_WAIT)) begin
         extWait <= extWait + CNT_W'(1);
      end
   end

   // External read pipeline: one valid per read grant, two cycles later
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         extRd1    <= 1'b0;
         oExtValid <= 1'b0;
         oExtRData <= '0;
      end else begin
         extRd1    <= extWin & ~iExtWe;
         oExtValid <= extRd1;
         if (extRd1) oExtRData <= iMemRData;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a one-cycle-latency RAM model.
// Inputs change 1 time unit after the rising edge; outputs are checked after.
module tb_dmem_arbiter;

   logic        iclk;
   logic        irst_n;
   logic        iCpuRead;
   logic        iCpuWrite;
   logic [15:0] iCpuAddr;
   logic [15:0] iCpuWData;
   logic [15:0] oCpuRData;
   logic        oCpuValid;
   logic        oStall;
   logic        iExtReq;
   logic        iExtWe;
   logic [15:0] iExtAddr;
   logic [15:0] iExtWData;
   logic        oExtGnt;
   logic [15:0] oExtRData;
   logic        oExtValid;
   logic        oMemEn;
   logic        oMemWe;
   logic [15:0] oMemAddr;
   logic [15:0] oMemWData;
   logic [15:0] iMemRData;

   logic [15:0] mem [0:65535];
   int          checks;
   int          errors;
   int          enCnt;
   int          vldCnt;

   dmem_arbiter #(
      .ADDR_W(16),
      .DATA_W(16),
      .MAX_WAIT(4)
   ) dut (
      .iclk(iclk),
      .irst_n(irst_n),
      .iCpuRead(iCpuRead),
      .iCpuWrite(iCpuWrite),
      .iCpuAddr(iCpuAddr),
      .iCpuWData(iCpuWData),
      .oCpuRData(oCpuRData),
      .oCpuValid(oCpuValid),
      .oStall(oStall),
      .iExtReq(iExtReq),
      .iExtWe(iExtWe),
      .iExtAddr(iExtAddr),
      .iExtWData(iExtWData),
      .oExtGnt(oExtGnt),
      .oExtRData(oExtRData),
      .oExtValid(oExtValid),
      .oMemEn(oMemEn),
      .oMemWe(oMemWe),
      .oMemAddr(oMemAddr),
      .oMemWData(oMemWData),
      .iMemRData(iMemRData)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   // Single-port RAM, read data valid the cycle after the enable
   always @(posedge iclk) begin
      if (oMemEn) begin
         if (oMemWe) mem[oMemAddr] <= oMemWData;
         else        iMemRData     <= mem[oMemAddr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      iMemRData = '0;
      mem[16'h0020] = 16'h1234;
      mem[16'h0030] = 16'h5678;
      irst_n    = 1'b0;
      iCpuRead  = 1'b1;
      iCpuWrite = 1'b0;
      iCpuAddr  = 16'h0010;
      iCpuWData = '0;
      iExtReq   = 1'b1;
      iExtWe    = 1'b0;
      iExtAddr  = 16'h0020;
      iExtWData = '0;

      // Reset: comb outputs gated even with requests present
      tick();
      chk("rst_memen", 32'(oMemEn), 32'd0);
      chk("rst_stall", 32'(oStall), 32'd0);
      chk("rst_gnt", 32'(oExtGnt), 32'd0);
      chk("rst_cvld", 32'(oCpuValid), 32'd0);
      chk("rst_evld", 32'(oExtValid), 32'd0);
      chk("rst_crd", 32'(oCpuRData), 32'd0);
      iCpuRead = 1'b0;
      iExtReq  = 1'b0;
      tick();
      irst_n = 1'b1;
      tick();

      // CPU store 0x0010 <= 0xBEEF
      iCpuWrite = 1'b1;
      iCpuAddr  = 16'h0010;
      iCpuWData = 16'hBEEF;
      #1;
      chk("st_en", 32'(oMemEn), 32'd1);
      chk("st_we", 32'(oMemWe), 32'd1);
      chk("st_addr", 32'(oMemAddr), 32'h0010);
      chk("st_wd", 32'(oMemWData), 32'hBEEF);
      chk("st_stall", 32'(oStall), 32'd0);
      tick();

      // CPU load 0x0010
      iCpuWrite = 1'b0;
      iCpuRead  = 1'b1;
      #1;
      chk("ld_t_en", 32'(oMemEn), 32'd1);
      chk("ld_t_we", 32'(oMemWe), 32'd0);
      chk("ld_t_stall", 32'(oStall), 32'd1);
      tick();
      chk("ld_t1_stall", 32'(oStall), 32'd1);
      chk("ld_t1_en", 32'(oMemEn), 32'd0);
      chk("ld_t1_vld", 32'(oCpuValid), 32'd0);
      tick();
      chk("ld_t2_vld", 32'(oCpuValid), 32'd1);
      chk("ld_t2_data", 32'(oCpuRData), 32'hBEEF);
      chk("ld_t2_stall", 32'(oStall), 32'd0);
      chk("ld_t2_en", 32'(oMemEn), 32'd0);
      iCpuRead = 1'b0;
      tick();
      chk("ld_t3_vld", 32'(oCpuValid), 32'd0);

      // Contention: CPU load 0x0030 vs external read 0x0020
      iCpuRead = 1'b1;
      iCpuAddr = 16'h0030;
      iExtReq  = 1'b1;
      iExtWe   = 1'b0;
      iExtAddr = 16'h0020;
      #1;
      chk("ct_t_gnt", 32'(oExtGnt), 32'd0);
      chk("ct_t_addr", 32'(oMemAddr), 32'h0030);
      chk("ct_t_stall", 32'(oStall), 32'd1);
      tick();
      chk("ct_t1_gnt", 32'(oExtGnt), 32'd1);
      chk("ct_t1_addr", 32'(oMemAddr), 32'h0020);
      chk("ct_t1_stall", 32'(oStall), 32'd1);
      tick();
      chk("ct_t2_cvld", 32'(oCpuValid), 32'd1);
      chk("ct_t2_crd", 32'(oCpuRData), 32'h5678);
      chk("ct_t2_evld", 32'(oExtValid), 32'd0);
      iExtReq  = 1'b0;
      iCpuRead = 1'b0;
      tick();
      chk("ct_t3_evld", 32'(oExtValid), 32'd1);
      chk("ct_t3_erd", 32'(oExtRData), 32'h1234);
      chk("ct_t3_cvld", 32'(oCpuValid), 32'd0);
      tick();
      chk("ct_t4_evld", 32'(oExtValid), 32'd0);

      // Starvation: CPU stores every cycle, external write held
      iExtReq   = 1'b1;
      iExtWe    = 1'b1;
      iExtAddr  = 16'h0040;
      iExtWData = 16'hAAAA;
      iCpuWrite = 1'b1;
      iCpuAddr  = 16'h0050;
      for (int i = 0; i < 4; i++) begin
         iCpuWData = 16'(i);
         #1;
         chk("sv_deny_gnt", 32'(oExtGnt), 32'd0);
         chk("sv_deny_stall", 32'(oStall), 32'd0);
         tick();
      end
      #1;
      chk("sv_force_gnt", 32'(oExtGnt), 32'd1);
      chk("sv_force_stall", 32'(oStall), 32'd1);
      chk("sv_force_addr", 32'(oMemAddr), 32'h0040);
      tick();
      iExtReq = 1'b0;
      #1;
      chk("sv_resume_gnt", 32'(oExtGnt), 32'd0);
      chk("sv_resume_stall", 32'(oStall), 32'd0);
      chk("sv_resume_addr", 32'(oMemAddr), 32'h0050);
      tick();
      iCpuWrite = 1'b0;
      tick();

      // External burst: writes then back-to-back reads
      for (int i = 0; i < 4; i++) begin
         iExtReq   = 1'b1;
         iExtWe    = 1'b1;
         iExtAddr  = 16'h0100 + 16'(i);
         iExtWData = 16'(i + 1);
         #1;
         chk("bw_gnt", 32'(oExtGnt), 32'd1);
         chk("bw_vld", 32'(oExtValid), 32'd0);
         tick();
      end
      for (int c = 0; c < 6; c++) begin
         iExtReq  = (c < 4);
         iExtWe   = 1'b0;
         iExtAddr = 16'h0100 + 16'(c);
         #1;
         chk("br_gnt", 32'(oExtGnt), 32'(c < 4));
         if (c >= 2) begin
            chk("br_vld", 32'(oExtValid), 32'd1);
            chk("br_data", 32'(oExtRData), 32'(c - 1));
         end else begin
            chk("br_vld", 32'(oExtValid), 32'd0);
         end
         tick();
      end
      iExtReq = 1'b0;

      // Request hold: read held through DONE issues one access
      enCnt    = 0;
      vldCnt   = 0;
      iCpuRead = 1'b1;
      iCpuAddr = 16'h0050;
      for (int c = 0; c < 3; c++) begin
         #1;
         enCnt  += int'(oMemEn);
         vldCnt += int'(oCpuValid);
         tick();
      end
      iCpuRead = 1'b0;
      vldCnt  += int'(oCpuValid);
      tick();
      vldCnt  += int'(oCpuValid);
      chk("hold_en_cnt", 32'(enCnt), 32'd1);
      chk("hold_vld_cnt", 32'(vldCnt), 32'd1);
      chk("hold_data", 32'(oCpuRData), 32'h0003);

      // Reset during RDWAIT drops the read
      iCpuRead = 1'b1;
      iCpuAddr = 16'h0010;
      tick();
      #1;
      irst_n = 1'b0;
      #1;
      chk("mr_stall", 32'(oStall), 32'd0);
      chk("mr_en", 32'(oMemEn), 32'd0);
      chk("mr_crd", 32'(oCpuRData), 32'd0);
      chk("mr_erd", 32'(oExtRData), 32'd0);
      tick();
      chk("mr_vld_a", 32'(oCpuValid), 32'd0);
      iCpuRead = 1'b0;
      irst_n   = 1'b1;
      tick();
      chk("mr_vld_b", 32'(oCpuValid), 32'd0);
      tick();
      chk("mr_vld_c", 32'(oCpuValid), 32'd0);

      // Fresh load after reset sees retained RAM contents
      iCpuRead = 1'b1;
      iCpuAddr = 16'h0010;
      #1;
      chk("pr_stall", 32'(oStall), 32'd1);
      tick();
      tick();
      chk("pr_vld", 32'(oCpuValid), 32'd1);
      chk("pr_data", 32'(oCpuRData), 32'hBEEF);
      iCpuRead = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
